// File: rtl/adc_jesd204_cpack_pkg.sv
// Shared constants and sizing helpers for the ADC channel packer.
//   SAMPLE_WIDTH        : width of one ADC sample (16 bits)
//   DEF_NUM_CHANNELS    : default channel count N
//   DEF_DATA_PATH_WIDTH : default samples per channel per beat D
//   word_slots()        : W = N*D, packed word size in samples
//   fill_width()        : width of the fill counter (clog2(2W))
//   count_width()       : width able to hold a per-beat sample count 0..W
package adc_jesd204_cpack_pkg;

  localparam int SAMPLE_WIDTH        = 16;
  localparam int DEF_NUM_CHANNELS    = 4;
  localparam int DEF_DATA_PATH_WIDTH = 4;

  function automatic int word_slots(input int n, input int d);
    return n * d;
  endfunction

  function automatic int fill_width(input int w);
    return (w < 1) ? 1 : $clog2(2 * w);
  endfunction

  function automatic int count_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/adc_jesd204_cpack_if.sv
// Bus between the JESD204 ADC core / DMA FIFO side and the channel packer.
//   adc_enable   : per-channel enables (quasi-static)
//   adc_valid    : per-channel beat valid
//   adc_data     : channel c, sample s at [16*(D*c+s) +: 16]
//   packed_valid : one-cycle strobe, packed_data holds a new word
//   packed_data  : packed word, slot k at [16*k +: 16]
//   packed_drop  : one-cycle pulse, partial data discarded on enable change
// master drives the ADC side; slave is the packer.
interface adc_jesd204_cpack_if
  import adc_jesd204_cpack_pkg::*;
#(
  parameter int NUM_CHANNELS    = DEF_NUM_CHANNELS,
  parameter int DATA_PATH_WIDTH = DEF_DATA_PATH_WIDTH
);
  localparam int W = word_slots(NUM_CHANNELS, DATA_PATH_WIDTH);

  logic [NUM_CHANNELS-1:0]   adc_enable;
  logic [NUM_CHANNELS-1:0]   adc_valid;
  logic [SAMPLE_WIDTH*W-1:0] adc_data;
  logic                      packed_valid;
  logic [SAMPLE_WIDTH*W-1:0] packed_data;
  logic                      packed_drop;

  modport master (
    output adc_enable, adc_valid, adc_data,
    input  packed_valid, packed_data, packed_drop
  );

  modport slave (
    input  adc_enable, adc_valid, adc_data,
    output packed_valid, packed_data, packed_drop
  );
endinterface

// File: rtl/adc_jesd204_cpack_compact.sv
// Combinational compaction mux: drops disabled channels and interleaves the
// enabled ones sample-major, channel-minor (s0 of each enabled channel in
// ascending index, then s1, ...).
//   enable       : channel enables
//   data_in      : channel c, sample s at [16*(D*c+s) +: 16]
//   data_out     : compacted samples at [16*k +: 16]; slots >= E*D are zero
//   sample_count : E*D, number of valid slots in data_out
module adc_jesd204_cpack_compact
  import adc_jesd204_cpack_pkg::*;
#(
  parameter int NUM_CHANNELS    = DEF_NUM_CHANNELS,
  parameter int DATA_PATH_WIDTH = DEF_DATA_PATH_WIDTH,
  localparam int W     = word_slots(NUM_CHANNELS, DATA_PATH_WIDTH),
  localparam int CNT_W = count_width(W)
) (
  input  logic [NUM_CHANNELS-1:0]   enable,
  input  logic [SAMPLE_WIDTH*W-1:0] data_in,
  output logic [SAMPLE_WIDTH*W-1:0] data_out,
  output logic [CNT_W-1:0]          sample_count
);
  logic [SAMPLE_WIDTH-1:0] in_slots  [W];
  logic [SAMPLE_WIDTH-1:0] out_slots [W];
  int slot_idx;
  int active_cnt;

  for (genvar gi = 0; gi < W; gi++) begin : g_slots
    assign in_slots[gi]                          = data_in[SAMPLE_WIDTH*gi +: SAMPLE_WIDTH];
    assign data_out[SAMPLE_WIDTH*gi +: SAMPLE_WIDTH] = out_slots[gi];
  end

  // The running slot index walks the output left to right, so each enabled
  // (sample, channel) pair lands in the next free slot.
  always_comb begin
    slot_idx   = 0;
    active_cnt = 0;
    for (int j = 0; j < W; j++) out_slots[j] = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (enable[c]) active_cnt++;
    end
    for (int s = 0; s < DATA_PATH_WIDTH; s++) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (enable[c]) begin
          out_slots[slot_idx] = in_slots[DATA_PATH_WIDTH*c + s];
          slot_idx++;
        end
      end
    end
    sample_count = CNT_W'(active_cnt * DATA_PATH_WIDTH);
  end
endmodule

// File: rtl/adc_jesd204_cpack.sv
// ADC channel packer. Removes disabled channels, interleaves the rest and
// emits full W-sample words to the DMA write FIFO. No backpressure.
//   adc_clk  : sole clock
//   adc_rstn : asynchronous active-low reset
//   bus      : slave side of adc_jesd204_cpack_if (ADC inputs, packed outputs)
// Stage 1 registers the compacted beat, its sample count, the accept flag and
// the enable-change flag. Stage 2 merges the beat into the fill buffer and
// registers packed_valid / packed_data / packed_drop.
module adc_jesd204_cpack
  import adc_jesd204_cpack_pkg::*;
#(
  parameter int NUM_CHANNELS    = DEF_NUM_CHANNELS,
  parameter int DATA_PATH_WIDTH = DEF_DATA_PATH_WIDTH
) (
  input logic adc_clk,
  input logic adc_rstn,
  adc_jesd204_cpack_if.slave bus
);
  localparam int W      = word_slots(NUM_CHANNELS, DATA_PATH_WIDTH);
  localparam int FILL_W = fill_width(W);
  localparam int CNT_W  = count_width(W);
  localparam int SW     = SAMPLE_WIDTH;

  logic [SW*W-1:0]         compact_data;
  logic [CNT_W-1:0]        compact_count;
  logic                    beat_accept;

  logic [NUM_CHANNELS-1:0] enable_reg;
  logic                    s1_accept_reg;
  logic                    s1_change_reg;
  logic [SW*W-1:0]         s1_data_reg;
  logic [CNT_W-1:0]        s1_count_reg;

  logic [FILL_W-1:0]       fill_reg;
  logic [SW-1:0]           buf_reg     [W];
  logic [SW-1:0]           beat_slots  [W];
  logic [SW-1:0]           merged      [2*W];
  logic [SW*W-1:0]         merged_word;
  logic                    word_done;
  int                      base_fill;
  int                      total_fill;

  adc_jesd204_cpack_compact #(
    .NUM_CHANNELS    (NUM_CHANNELS),
    .DATA_PATH_WIDTH (DATA_PATH_WIDTH)
  ) u_compact (
    .enable       (bus.adc_enable),
    .data_in      (bus.adc_data),
    .data_out     (compact_data),
    .sample_count (compact_count)
  );

  // With no channel enabled nothing can be accepted.
  assign beat_accept = |(bus.adc_valid & bus.adc_enable);

  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      enable_reg    <= '0;
      s1_accept_reg <= 1'b0;
      s1_change_reg <= 1'b0;
      s1_data_reg   <= '0;
      s1_count_reg  <= '0;
    end else begin
      enable_reg    <= bus.adc_enable;
      s1_change_reg <= (bus.adc_enable != enable_reg);
      s1_accept_reg <= beat_accept;
      s1_data_reg   <= compact_data;
      s1_count_reg  <= compact_count;
    end
  end

  for (genvar gi = 0; gi < W; gi++) begin : g_word
    assign beat_slots[gi]                = s1_data_reg[SW*gi +: SW];
    assign merged_word[SW*gi +: SW]      = merged[gi];
  end

  // merged is the 2W-slot view of the buffer after appending the beat. Only
  // the low W slots are kept between cycles because the fill stays below W.
  // An enable change restarts packing at slot 0 for the beat of that cycle.
  always_comb begin
    base_fill  = s1_change_reg ? 0 : int'(fill_reg);
    total_fill = base_fill + (s1_accept_reg ? int'(s1_count_reg) : 0);
    for (int j = 0; j < W; j++)     merged[j] = buf_reg[j];
    for (int j = W; j < 2 * W; j++) merged[j] = '0;
    if (s1_accept_reg) begin
      for (int i = 0; i < W; i++) begin
        if (i < int'(s1_count_reg)) merged[base_fill + i] = beat_slots[i];
      end
    end
    word_done = (total_fill >= W);
  end

  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      fill_reg         <= '0;
      bus.packed_valid <= 1'b0;
      bus.packed_drop  <= 1'b0;
      bus.packed_data  <= '0;
      for (int j = 0; j < W; j++) buf_reg[j] <= '0;
    end else begin
      bus.packed_valid <= word_done;
      bus.packed_drop  <= s1_change_reg && (fill_reg != '0);
      if (word_done) begin
        bus.packed_data <= merged_word;
        fill_reg        <= FILL_W'(total_fill - W);
        for (int j = 0; j < W; j++) buf_reg[j] <= merged[j + W];
      end else begin
        fill_reg <= FILL_W'(total_fill);
        for (int j = 0; j < W; j++) buf_reg[j] <= merged[j];
      end
    end
  end
endmodule

// File: tb/tb_adc_jesd204_cpack.sv
// Self-checking bench for adc_jesd204_cpack (N=4, D=2, W=8). A queue-based
// sample model predicts every packed word and drop pulse two edges after the
// beat is presented.
module tb_adc_jesd204_cpack;
  localparam int N  = 4;
  localparam int D  = 2;
  localparam int W  = N * D;
  localparam int DW = 16 * W;

  logic adc_clk  = 1'b0;
  logic adc_rstn = 1'b0;
  always #5 adc_clk = ~adc_clk;

  adc_jesd204_cpack_if #(.NUM_CHANNELS(N), .DATA_PATH_WIDTH(D)) bus ();

  adc_jesd204_cpack #(.NUM_CHANNELS(N), .DATA_PATH_WIDTH(D)) dut (
    .adc_clk  (adc_clk),
    .adc_rstn (adc_rstn),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [15:0]   sample_q [$];
  logic [N-1:0]  model_en   = '0;
  logic          pend_valid = 1'b0;
  logic          pend_drop  = 1'b0;
  logic [DW-1:0] pend_word  = '0;
  logic          obs_valid;
  logic          obs_drop;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  // Present one beat, clock it, compare outputs owed by the previous beat.
  task automatic step(input logic [N-1:0] en, input logic [N-1:0] vld, input logic [DW-1:0] data);
    logic          nv;
    logic          nd;
    logic [DW-1:0] nw;
    bus.adc_enable = en;
    bus.adc_valid  = vld;
    bus.adc_data   = data;
    nv = 1'b0;
    nd = 1'b0;
    nw = pend_word;
    if (en != model_en) begin
      nd = (sample_q.size() != 0);
      sample_q.delete();
    end
    model_en = en;
    if ((vld & en) != '0) begin
      for (int s = 0; s < D; s++)
        for (int c = 0; c < N; c++)
          if (en[c]) sample_q.push_back(data[16*(D*c+s) +: 16]);
      if (sample_q.size() >= W) begin
        nv = 1'b1;
        for (int k = 0; k < W; k++) nw[16*k +: 16] = sample_q.pop_front();
      end
    end
    @(posedge adc_clk);
    #1;
    obs_valid = bus.packed_valid;
    obs_drop  = bus.packed_drop;
    check("packed_valid", DW'(bus.packed_valid), DW'(pend_valid));
    check("packed_drop",  DW'(bus.packed_drop),  DW'(pend_drop));
    check("packed_data",  bus.packed_data,       pend_word);
    pend_valid = nv;
    pend_drop  = nd;
    pend_word  = nw;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, DW'(bus.packed_valid), '0);
    check({tag, "_drop"},  DW'(bus.packed_drop),  '0);
    check({tag, "_data"},  bus.packed_data,       '0);
  endtask

  initial begin
    logic [DW-1:0] d1;
    logic [DW-1:0] t1_word;
    logic [7:0]    t3_mask;
    int            t2_valids;
    int            seg_len;
    logic [N-1:0]  seg_en;
    logic [N-1:0]  vld;

    bus.adc_enable = '0;
    bus.adc_valid  = '0;
    bus.adc_data   = '0;

    // power-on reset
    repeat (2) @(posedge adc_clk);
    #1;
    check_reset_outputs("por");
    @(negedge adc_clk);
    adc_rstn = 1'b1;

    // T1: all channels, sample value 16*c+s, word every beat
    for (int c = 0; c < N; c++)
      for (int s = 0; s < D; s++) d1[16*(D*c+s) +: 16] = 16'(16 * c + s);
    for (int k = 0; k < W; k++) t1_word[16*k +: 16] = 16'(16 * (k % N) + (k / N));
    step(4'b1111, 4'b1111, d1);
    check("t1_latency", DW'(obs_valid), '0);
    step(4'b1111, 4'b1111, d1);
    check("t1_first_valid", DW'(obs_valid), DW'(1'b1));
    check("t1_word", bus.packed_data, t1_word);
    step(4'b1111, 4'b1111, d1);
    check("t1_word_repeat", bus.packed_data, t1_word);
    step(4'b1111, 4'b1111, d1);

    // T2: single channel 2, one word after the fourth beat
    t2_valids = 0;
    step(4'b0100, 4'b0100, rand_word());
    for (int b = 1; b < 4; b++) begin
      step(4'b0100, 4'b0100, rand_word());
      if (obs_valid) t2_valids++;
    end
    step(4'b0100, 4'b0000, rand_word());
    if (obs_valid) t2_valids++;
    check("t2_valid_count", DW'(t2_valids), DW'(1));
    check("t2_valid_after_beat4", DW'(obs_valid), DW'(1'b1));

    // T3: E=3, words after beats 2,3,4,6,7,8
    t3_mask = '0;
    step(4'b1011, 4'b1011, rand_word());
    for (int b = 1; b < 8; b++) begin
      step(4'b1011, 4'b1011, rand_word());
      t3_mask[b-1] = obs_valid;
    end
    step(4'b1011, 4'b0000, rand_word());
    t3_mask[7] = obs_valid;
    check("t3_valid_pattern", DW'(t3_mask), DW'(8'b1110_1110));

    // T4: partial fill then enable change -> drop pulse, fresh alignment
    step(4'b0001, 4'b0001, rand_word());
    step(4'b0010, 4'b0010, rand_word());
    step(4'b0010, 4'b0010, rand_word());
    check("t4_drop_pulse", DW'(obs_drop), DW'(1'b1));
    step(4'b0010, 4'b0010, rand_word());
    step(4'b0010, 4'b0010, rand_word());
    step(4'b0010, 4'b0000, rand_word());
    check("t4_new_word", DW'(obs_valid), DW'(1'b1));

    // T5: reset mid-burst with nonzero fill
    step(4'b0001, 4'b0001, rand_word());
    step(4'b0001, 4'b0001, rand_word());
    #2;
    adc_rstn = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    sample_q.delete();
    model_en   = '0;
    pend_valid = 1'b0;
    pend_drop  = 1'b0;
    pend_word  = '0;
    bus.adc_valid = '0;
    repeat (2) @(posedge adc_clk);
    #1;
    check_reset_outputs("rst_hold");
    @(negedge adc_clk);
    adc_rstn = 1'b1;
    for (int b = 0; b < 4; b++) step(4'b0001, 4'b0001, rand_word());
    step(4'b0001, 4'b0000, rand_word());
    check("t5_post_reset_word", DW'(obs_valid), DW'(1'b1));

    // T6: random enables held >= 20 beats, random valid gaps
    for (int seg = 0; seg < 12; seg++) begin
      seg_en  = N'($urandom_range(0, (1 << N) - 1));
      seg_len = 20 + $urandom_range(0, 10);
      for (int b = 0; b < seg_len; b++) begin
        vld = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
        step(seg_en, vld, rand_word());
      end
    end
    step(bus.adc_enable, '0, '0);
    step(bus.adc_enable, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
